bitonic_sort_seq: RTL and testbench

Parametrised, sequential bitonic sorter: accepts one vector of N = 2^LOG_N unsigned or signed words through a valid/ready handshake and sorts it in place, ascending or descending per vector. It executes one bitonic compare-exchange layer per clock on a shared bank of N/2 comparators, then presents the sorted vector through a second valid/ready handshake. It is the clocked, generalised successor to the team's fixed 8 × 8-bit combinational sorting network, for use wherever a vector must be sorted without a full unrolled network.

---
 rtl/sort_pkg.sv | 22 ++
 rtl/cmp_swap.sv | 38 +++
 rtl/bitonic_sort_seq.sv | 162 ++++++++++++++++
 tb/tb_bitonic_sort_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and helpers for the sequential bitonic sorter.
//   sort_state_t : controller states (IDLE, SORT, DONE)
//   ASC / DESC   : encodings of the per-vector sort direction
//   n_layers()   : number of compare-exchange layers for 2^log_n elements
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } sort_state_t;

    localparam logic ASC  = 1'b0;
    localparam logic DESC = 1'b1;

    // A full bitonic network over 2^log_n inputs has log_n merge stages,
    // stage p containing p+1 layers.
    function automatic int n_layers(input int log_n);
        return (log_n * (log_n + 1)) / 2;
    endfunction

endpackage

// File: rtl/cmp_swap.sv
// Single combinational compare-exchange element.
//   a, b  : element from the lower / higher index of the pair
//   asc   : 1 = put the smaller value on lo, 0 = put the larger value on lo
//   lo    : value written back to the lower index
//   hi    : value written back to the higher index
// Equal inputs are never swapped, so the element is order-stable on ties.
module cmp_swap
    import sort_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             asc,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic a_gt_b;
    logic a_lt_b;
    logic swap;

    generate
        if (SIGNED != 0) begin : g_signed
            assign a_gt_b = $signed(a) > $signed(b);
            assign a_lt_b = $signed(a) < $signed(b);
        end else begin : g_unsigned
            assign a_gt_b = a > b;
            assign a_lt_b = a < b;
        end
    endgenerate

    assign swap = asc ? a_gt_b : a_lt_b;
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/bitonic_sort_seq.sv
// Sequential bitonic sorter: one compare-exchange layer per clock on a
// shared bank of N/2 comparators.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake; in_data and in_dir taken together
//   in_dir              : 0 = ascending, 1 = descending
//   in_data             : N packed elements, element i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready : output handshake; out_data is the data register
//   busy                : high while layers are being applied
module bitonic_sort_seq
    import sort_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LOG_N  = 3,
    parameter int SIGNED = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_dir,
    input  logic [(WIDTH << LOG_N)-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [(WIDTH << LOG_N)-1:0]   out_data,
    output logic                          busy
);

    localparam int N    = 1 << LOG_N;
    localparam int HALF = N / 2;
    localparam int CW   = 3;    // holds layer counters up to LOG_N = 5

    typedef logic [WIDTH-1:0] elem_t;

    sort_state_t     state_reg, state_next;
    logic [CW-1:0]   p_reg, p_next;
    logic [CW-1:0]   q_reg, q_next;
    logic            dir_reg, dir_next;
    elem_t           data_reg  [N];
    elem_t           data_next [N];
    elem_t           in_arr    [N];
    elem_t           layer_arr [N];

    logic [LOG_N-1:0] idx_lo  [HALF];
    logic [LOG_N-1:0] idx_hi  [HALF];
    elem_t            pair_lo [HALF];
    elem_t            pair_hi [HALF];
    logic             pair_asc[HALF];

    genvar gi;

    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign in_arr[gi]                    = in_data[gi*WIDTH +: WIDTH];
            assign out_data[gi*WIDTH +: WIDTH]   = data_reg[gi];
        end
    endgenerate

    // Comparator gi serves pair index gi: its lower element index is gi with
    // a 0 inserted at bit position q, the upper one has a 1 there.
    generate
        for (gi = 0; gi < HALF; gi++) begin : g_pair
            always_comb begin : c_route
                int   lo_i;
                logic bitp;
                lo_i = 0;
                for (int qq = 0; qq < LOG_N; qq++) begin
                    if (int'(q_reg) == qq) begin
                        lo_i = ((gi >> qq) << (qq + 1)) | (gi & ((1 << qq) - 1));
                    end
                end
                idx_lo[gi] = LOG_N'(lo_i);
                idx_hi[gi] = LOG_N'(lo_i | (1 << q_reg));
                // lo_i < N, so bit LOG_N reads as 0: the last merge follows dir.
                bitp         = lo_i[int'(p_reg) + 1];
                pair_asc[gi] = ~(bitp ^ (dir_reg == DESC));
            end

            cmp_swap #(
                .WIDTH  (WIDTH),
                .SIGNED (SIGNED)
            ) u_cmp (
                .a   (data_reg[idx_lo[gi]]),
                .b   (data_reg[idx_hi[gi]]),
                .asc (pair_asc[gi]),
                .lo  (pair_lo[gi]),
                .hi  (pair_hi[gi])
            );
        end
    endgenerate

    // Every element belongs to exactly one pair in a layer, so each slot is
    // overwritten once.
    always_comb begin
        layer_arr = data_reg;
        for (int k = 0; k < HALF; k++) begin
            layer_arr[idx_lo[k]] = pair_lo[k];
            layer_arr[idx_hi[k]] = pair_hi[k];
        end
    end

    always_comb begin
        state_next = state_reg;
        p_next     = p_reg;
        q_next     = q_reg;
        dir_next   = dir_reg;
        data_next  = data_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_next  = in_arr;
                    dir_next   = in_dir;
                    p_next     = '0;
                    q_next     = '0;
                    state_next = SORT;
                end
            end
            SORT: begin
                busy      = 1'b1;
                data_next = layer_arr;
                if (q_reg == '0 && p_reg == CW'(LOG_N - 1)) begin
                    state_next = DONE;
                end else if (q_reg == '0) begin
                    // Next merge stage starts at its widest distance.
                    p_next = p_reg + 3'd1;
                    q_next = p_reg + 3'd1;
                end else begin
                    q_next = q_reg - 3'd1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            p_reg     <= '0;
            q_reg     <= '0;
            dir_reg   <= ASC;
            for (int k = 0; k < N; k++) begin
                data_reg[k] <= '0;
            end
        end else begin
            state_reg <= state_next;
            p_reg     <= p_next;
            q_reg     <= q_next;
            dir_reg   <= dir_next;
            data_reg  <= data_next;
        end
    end

endmodule

// File: tb/tb_bitonic_sort_seq.sv
// Self-checking bench for bitonic_sort_seq: directed vectors on 8x8-bit
// unsigned and signed instances, back-pressure and mid-sort reset, plus a
// parameter sweep against a plain reference sort.
module tb_bitonic_sort_seq;
    import sort_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic rst_n    = 1'b0;
    logic sw_rst_n = 1'b0;
    logic [3:0] sw_done = 4'b0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: interpret each element as a number, sort, reverse for desc.
    function automatic logic [511:0] ref_sort(input int n, input int w, input bit sgn,
                                              input bit dir, input logic [511:0] din);
        longint keys[32];
        longint t;
        longint v;
        logic [511:0] r;
        int idx;
        for (int i = 0; i < n; i++) begin
            keys[i] = 0;
            for (int b = 0; b < w; b++) keys[i][b] = din[i*w + b];
            if (sgn && din[i*w + w - 1]) keys[i] = keys[i] - (longint'(1) << w);
        end
        for (int i = 1; i < n; i++) begin
            t = keys[i];
            idx = i - 1;
            while (idx >= 0 && keys[idx] > t) begin
                keys[idx + 1] = keys[idx];
                idx--;
            end
            keys[idx + 1] = t;
        end
        r = '0;
        for (int i = 0; i < n; i++) begin
            v = dir ? keys[n - 1 - i] : keys[i];
            for (int b = 0; b < w; b++) r[i*w + b] = v[b];
        end
        return r;
    endfunction

    function automatic logic [63:0] pk(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    // ---------------- 8 x 8-bit unsigned instance ----------------
    logic        a_in_valid = 1'b0, a_in_dir = 1'b0, a_out_ready = 1'b0;
    logic [63:0] a_in_data = '0;
    logic        a_in_ready, a_out_valid, a_busy;
    logic [63:0] a_out_data;

    bitonic_sort_seq #(.WIDTH(8), .LOG_N(3), .SIGNED(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_dir(a_in_dir), .in_data(a_in_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy));

    // ---------------- 8 x 8-bit signed instance ----------------
    logic        s_in_valid = 1'b0, s_in_dir = 1'b0, s_out_ready = 1'b0;
    logic [63:0] s_in_data = '0;
    logic        s_in_ready, s_out_valid, s_busy;
    logic [63:0] s_out_data;

    bitonic_sort_seq #(.WIDTH(8), .LOG_N(3), .SIGNED(1)) u_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_dir(s_in_dir), .in_data(s_in_data), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_data(s_out_data), .busy(s_busy));

    task automatic run_a(input string name, input logic [63:0] vec, input bit dir,
                         input logic [63:0] lit);
        logic [511:0] e512;
        int lat;
        e512 = ref_sort(8, 8, 1'b0, dir, {448'b0, vec});
        a_in_data  = vec;
        a_in_dir   = dir;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        chk({name, " busy"}, {511'b0, a_busy}, 512'd1);
        lat = 0;
        while (!a_out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, " latency"}, lat, 512'd6);
        chk({name, " model"}, {448'b0, a_out_data}, e512);
        chk({name, " literal"}, {448'b0, a_out_data}, {448'b0, lit});
        chk({name, " in_ready in DONE"}, {511'b0, a_in_ready}, 512'd0);
        $display("txn %s dir=%0d in=%h out=%h lat=%0d", name, dir, vec, a_out_data, lat);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        chk({name, " out_valid drop"}, {511'b0, a_out_valid}, 512'd0);
        chk({name, " in_ready back"}, {511'b0, a_in_ready}, 512'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        logic [63:0] v_mix;
        logic [63:0] held;
        int lat;
        int guard;

        v_mix = pk(8'h07, 8'h03, 8'hFF, 8'h00, 8'h05, 8'h05, 8'h01, 8'h80);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset out_valid", {511'b0, a_out_valid}, 512'd0);
        chk("reset in_ready", {511'b0, a_in_ready}, 512'd1);
        chk("reset busy", {511'b0, a_busy}, 512'd0);
        chk("reset data", {448'b0, a_out_data}, 512'd0);

        run_a("asc", v_mix, 1'b0, pk(8'h00, 8'h01, 8'h03, 8'h05, 8'h05, 8'h07, 8'h80, 8'hFF));
        run_a("desc", v_mix, 1'b1, pk(8'hFF, 8'h80, 8'h07, 8'h05, 8'h05, 8'h03, 8'h01, 8'h00));
        run_a("equal", {8{8'h2A}}, 1'b0, {8{8'h2A}});

        // Signed compare
        s_in_data  = pk(8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'h10, 8'h90);
        s_in_dir   = 1'b0;
        s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("signed latency", lat, 512'd6);
        chk("signed literal", {448'b0, s_out_data},
            {448'b0, pk(8'h80, 8'h90, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h10, 8'h7F)});
        chk("signed model", {448'b0, s_out_data}, ref_sort(8, 8, 1'b1, 1'b0, {448'b0, s_in_data}));
        $display("txn signed in=%h out=%h lat=%0d", s_in_data, s_out_data, lat);
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;

        // Back-pressure: output held, input pulses ignored
        a_in_data  = v_mix;
        a_in_dir   = 1'b0;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp latency", lat, 512'd6);
        held = pk(8'h00, 8'h01, 8'h03, 8'h05, 8'h05, 8'h07, 8'h80, 8'hFF);
        for (int c = 0; c < 10; c++) begin
            a_in_valid = c[0];
            a_in_data  = {$urandom, $urandom};
            a_in_dir   = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("bp stable %0d", c), {448'b0, a_out_data}, {448'b0, held});
            chk($sformatf("bp in_ready %0d", c), {511'b0, a_in_ready}, 512'd0);
            chk($sformatf("bp out_valid %0d", c), {511'b0, a_out_valid}, 512'd1);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        chk("bp release in_ready", {511'b0, a_in_ready}, 512'd1);
        @(posedge clk); #1;
        chk("bp idle busy", {511'b0, a_busy}, 512'd0);
        $display("txn backpressure out=%h", held);

        // Reset mid-SORT discards the vector
        a_in_data  = v_mix;
        a_in_dir   = 1'b1;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre-reset busy", {511'b0, a_busy}, 512'd1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midreset out_valid", {511'b0, a_out_valid}, 512'd0);
        chk("midreset in_ready", {511'b0, a_in_ready}, 512'd1);
        chk("midreset busy", {511'b0, a_busy}, 512'd0);
        chk("midreset data", {448'b0, a_out_data}, 512'd0);
        @(posedge clk); #1;
        chk("midreset stays idle", {511'b0, a_out_valid}, 512'd0);
        $display("txn midreset");
        run_a("after reset", pk(8'h10, 8'h02, 8'hC0, 8'h02, 8'h33, 8'h01, 8'hEE, 8'h44), 1'b0,
              pk(8'h01, 8'h02, 8'h02, 8'h10, 8'h33, 8'h44, 8'hC0, 8'hEE));

        guard = 0;
        while (!(&sw_done) && guard < 60000) begin
            @(posedge clk);
            guard++;
        end
        chk("sweep finished", {508'b0, sw_done}, {508'b0, 4'hF});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin : sw_reset
        repeat (3) @(posedge clk);
        #1 sw_rst_n = 1'b1;
    end

    // ---------------- parameter sweep ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sw
            localparam int L = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 4 : 5;
            localparam int W = (gi == 0) ? 1 : (gi == 1) ? 16 : (gi == 2) ? 1 : 16;
            localparam int N = 1 << L;
            localparam int S = n_layers(L);

            logic           iv = 1'b0, idr = 1'b0, ordy = 1'b0;
            logic           ir, ov, bsy;
            logic [N*W-1:0] idat = '0;
            logic [N*W-1:0] odat;

            bitonic_sort_seq #(.WIDTH(W), .LOG_N(L), .SIGNED(0)) u_dut (
                .clk(clk), .rst_n(sw_rst_n), .in_valid(iv), .in_ready(ir),
                .in_dir(idr), .in_data(idat), .out_valid(ov),
                .out_ready(ordy), .out_data(odat), .busy(bsy));

            initial begin : drive
                logic [511:0] rnd;
                logic [511:0] din;
                logic [511:0] dout;
                logic [511:0] e;
                int lat;
                int st;
                repeat (5) @(posedge clk);
                #1;
                for (int v = 0; v < 500; v++) begin
                    st = $urandom_range(0, 3);
                    repeat (st) begin
                        @(posedge clk); #1;
                    end
                    for (int k = 0; k < 16; k++) rnd[k*32 +: 32] = $urandom;
                    idat = rnd[N*W-1:0];
                    idr  = 1'($urandom_range(0, 1));
                    iv   = 1'b1;
                    st = 0;
                    while (!ir && st < 100) begin
                        @(posedge clk); #1;
                        st++;
                    end
                    @(posedge clk); #1;
                    iv = 1'b0;
                    din = '0;
                    din[N*W-1:0] = idat;
                    e = ref_sort(N, W, 1'b0, idr, din);
                    lat = 0;
                    while (!ov && lat < 100) begin
                        @(posedge clk); #1;
                        lat++;
                    end
                    dout = '0;
                    dout[N*W-1:0] = odat;
                    chk($sformatf("sw L%0d W%0d v%0d latency", L, W, v), lat, S);
                    chk($sformatf("sw L%0d W%0d v%0d data", L, W, v), dout, e);
                    $display("txn sweep L=%0d W=%0d v=%0d dir=%0d out=%h lat=%0d", L, W, v, idr, odat, lat);
                    st = $urandom_range(0, 3);
                    repeat (st) begin
                        @(posedge clk); #1;
                    end
                    ordy = 1'b1;
                    @(posedge clk); #1;
                    ordy = 1'b0;
                end
                sw_done[gi] = 1'b1;
            end
        end
    endgenerate

endmodule
